// File: rtl/zfsoc_button_pio.sv
// Avalon-MM input PIO for buttons/switches: sync, debounce, edge capture and maskable IRQ.
// Build macro BUTTON_PIO_DEBOUNCE_EN enables the per-bit debouncer; without it the level is the synchroniser output.
module zfsoc_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_TYPE       = 1,
  parameter int IDLE_LEVEL      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL[0]}};

  logic [WIDTH-1:0] sync0;
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] ec_clr;
  logic [31:0]      rd_next;
  logic             bus_write;
  logic             unused_writedata;

  assign unused_writedata = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= IDLE_VEC;
      sync1 <= IDLE_VEC;
    end else begin
      sync0 <= in_port;
      sync1 <= sync0;
    end
  end

`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt [WIDTH];

  // A bit must disagree with the accepted level for DEBOUNCE_CYCLES consecutive cycles to flip it.
  always_ff @(posedge clk) begin
    if (reset) begin
      level <= IDLE_VEC;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync1[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          level[i] <= sync1[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign level = sync1;
`endif

  always_ff @(posedge clk) begin
    if (reset) prev <= IDLE_VEC;
    else       prev <= level;
  end

  always_comb begin
    edge_set = '0;
    case (EDGE_TYPE)
      0:       edge_set = ~prev & level;
      1:       edge_set = prev & ~level;
      default: edge_set = prev ^ level;
    endcase
  end

  assign bus_write = chipselect & ~write_n;

  always_comb begin
    ec_clr = '0;
    if (bus_write && address == 2'd3) ec_clr = writedata[WIDTH-1:0];
  end

  // Set is OR-ed in after the clear so an edge landing on a clear write is kept.
  always_ff @(posedge clk) begin
    if (reset) begin
      edgecapture <= '0;
      irqmask     <= '0;
    end else begin
      edgecapture <= (edgecapture & ~ec_clr) | edge_set;
      if (bus_write && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (address)
      2'd0:    rd_next[WIDTH-1:0] = level;
      2'd2:    rd_next[WIDTH-1:0] = irqmask;
      2'd3:    rd_next[WIDTH-1:0] = edgecapture;
      default: rd_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) readdata <= '0;
    else       readdata <= rd_next;
  end

  assign irq = |(edgecapture & irqmask);

endmodule

// File: tb/tb_zfsoc_button_pio.sv
// Bench for zfsoc_button_pio: directed steps then random traffic, checked against a history-based reference model.
module tb_zfsoc_button_pio;

  localparam int W  = 4;
  localparam int D  = 4;
  localparam int ET = 1;
  localparam logic [3:0] IDLE = 4'hF;
`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int LAT = 2 + D;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  int tests = 0;
  int fails = 0;

  // Model: raw sample history and accepted-level history indexed by clock edge.
  int          n = 16;
  logic [3:0]  raw_h [4096];
  logic [3:0]  lvl_h [4096];
  logic [3:0]  m_mask = '0;
  logic [3:0]  m_ec = '0;
  logic [31:0] m_rd = '0;
  logic [31:0] exp_q[$];

  zfsoc_button_pio #(
    .WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(ET), .IDLE_LEVEL(1)
  ) dut (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] edge_of(logic [3:0] p, logic [3:0] c);
    case (ET)
      0:       return ~p & c;
      1:       return p & ~c;
      default: return p ^ c;
    endcase
  endfunction

  task automatic model_edge();
    logic [3:0] clr;
    logic       flip;
    n++;
    if (reset) begin
      for (int j = n - D - 2; j <= n; j++) raw_h[j] = IDLE;
      lvl_h[n-1] = IDLE;
      lvl_h[n]   = IDLE;
      m_mask = '0;
      m_ec   = '0;
      m_rd   = '0;
    end else begin
      raw_h[n] = in_port;
`ifdef BUTTON_PIO_DEBOUNCE_EN
      for (int b = 0; b < W; b++) begin
        flip = 1'b1;
        for (int j = 2; j <= D + 1; j++)
          if (raw_h[n-j][b] == lvl_h[n-1][b]) flip = 1'b0;
        lvl_h[n][b] = flip ? ~lvl_h[n-1][b] : lvl_h[n-1][b];
      end
`else
      lvl_h[n] = raw_h[n-1];
`endif
      m_rd = '0;
      case (address)
        2'd0:    m_rd[3:0] = lvl_h[n-1];
        2'd2:    m_rd[3:0] = m_mask;
        2'd3:    m_rd[3:0] = m_ec;
        default: m_rd = '0;
      endcase
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0;
      m_ec = (m_ec & ~clr) | edge_of(lvl_h[n-2], lvl_h[n-1]);
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[3:0];
    end
    exp_q.push_back(m_rd);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_readdata", readdata, exp_q.pop_front());
    chk("model_irq", {31'b0, irq}, {31'b0, |(m_ec & m_mask)});
  endtask

  task automatic bus_idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic rd_const(input logic [1:0] a, input logic [31:0] e, input string tag);
    address = a;
    tick();
    chk(tag, readdata, e);
  endtask

  initial begin
    int hold;
    for (int i = 0; i < 4096; i++) begin
      raw_h[i] = IDLE;
      lvl_h[i] = IDLE;
    end
    reset = 1'b1; in_port = IDLE; address = 2'd0; writedata = '0;
    bus_idle();
    repeat (3) tick();
    reset = 1'b0;

    rd_const(2'd0, 32'hF, "reset_data");
    rd_const(2'd2, 32'h0, "reset_mask");
    rd_const(2'd3, 32'h0, "reset_ec");
    chk("reset_irq", {31'b0, irq}, 32'h0);

    in_port = 4'hE; address = 2'd3;
    repeat (LAT + 1) tick();
    rd_const(2'd3, 32'h1, "press_ec");
    rd_const(2'd0, 32'hE, "press_data");
    bus_wr(2'd3, 32'h1);
    rd_const(2'd3, 32'h0, "ec_cleared");

    in_port = 4'hF;
    repeat (LAT + 2) tick();
    rd_const(2'd0, 32'hF, "release_data");
    rd_const(2'd3, 32'h0, "release_no_ec");

    in_port = 4'hE;
    repeat (3) tick();
    in_port = 4'hF; address = 2'd0;
    repeat (LAT + 3) tick();
`ifdef BUTTON_PIO_DEBOUNCE_EN
    rd_const(2'd0, 32'hF, "glitch_data");
    rd_const(2'd3, 32'h0, "glitch_ec");
`endif
    bus_wr(2'd3, 32'hF);

    bus_wr(2'd2, 32'h1);
    in_port = 4'hE;
    repeat (LAT + 1) tick();
    chk("irq_set", {31'b0, irq}, 32'h1);
    bus_wr(2'd3, 32'h1);
    chk("irq_clr", {31'b0, irq}, 32'h0);
    rd_const(2'd3, 32'h0, "irq_clr_ec");

    in_port = 4'hF;
    repeat (LAT + 2) tick();
    in_port = 4'hE;
    repeat (LAT + 1) tick();
    chk("irq_again", {31'b0, irq}, 32'h1);
    in_port = 4'hF;
    repeat (LAT + 2) tick();
    in_port = 4'hE;
    repeat (LAT) tick();
    bus_wr(2'd3, 32'h1);
    chk("setwins_irq", {31'b0, irq}, 32'h1);
    rd_const(2'd3, 32'h1, "setwins_ec");
    bus_wr(2'd3, 32'hF);

`ifndef BUTTON_PIO_DEBOUNCE_EN
    in_port = 4'hF;
    repeat (4) tick();
    bus_wr(2'd3, 32'hF);
    in_port = 4'h7; address = 2'd0;
    tick();
    tick();
    chk("nodeb_early", readdata, 32'hF);
    tick();
    chk("nodeb_data", readdata, 32'h7);
    in_port = 4'hF;
    repeat (LAT + 2) tick();
    bus_wr(2'd3, 32'hF);
`endif

    in_port = 4'h0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; in_port = 4'hF;
    repeat (LAT + 3) tick();
    rd_const(2'd3, 32'h0, "rst_no_ec");
    rd_const(2'd0, 32'hF, "rst_data");
    rd_const(2'd2, 32'h0, "rst_mask");

    hold = 0;
    for (int c = 0; c < 400; c++) begin
      if (hold == 0) begin
        in_port = 4'($urandom_range(0, 15));
        hold    = int'($urandom_range(1, 2 * D + 2));
      end
      hold--;
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom;
      reset      = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;
    bus_idle();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
